// File: rtl/urx_deser_pkg.sv
// Shared constants for the UART receive deserializer: FSM state encoding
// and the default bit period for a 50 MHz clock at 115200 baud.
package urx_deser_pkg;

  localparam int URX_BAUD_DIV_DEF = 434;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } urx_state_e;

endpackage

// File: rtl/urx_baud_cnt.sv
// Free-running 16-bit bit-period counter. It wraps on the half-period
// terminal count while half_mode is set (start-bit centering), otherwise on
// the full-period terminal count. clr forces it back to 0 on the next edge.
module urx_baud_cnt #(
  parameter int BAUD_DIV = 434
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic clr,
  input  logic half_mode,
  output logic tick_half,
  output logic tick_full
);

  localparam logic [15:0] HALF_TC = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL_TC = 16'(BAUD_DIV - 1);

  logic [15:0] cnt;

  assign tick_half = (cnt == HALF_TC);
  assign tick_full = (cnt == FULL_TC);

  // Count up every cycle; wrap to 0 on the active terminal count or on clear.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      cnt <= 16'd0;
    end else if (clr) begin
      cnt <= 16'd0;
    end else if (half_mode ? tick_half : tick_full) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/urx_deser.sv
// UART receive deserializer (8N1 or 8E1). Detects the start edge, centres on
// the start bit, samples each following bit once per bit period, and reports
// a good byte, a framing error or a parity error as one-cycle pulses on the
// cycle after the stop bit is sampled.
//
// Output handshake: rx_vld, rx_ferr and rx_perr are single-cycle strobes with
// no ready/back-pressure; at most one of them is high in any cycle. rx_data
// changes only together with an rx_vld pulse and holds its value otherwise;
// a consumer that misses a pulse simply sees the byte overwritten.
module urx_deser
  import urx_deser_pkg::*;
#(
  parameter int BAUD_DIV  = URX_BAUD_DIV_DEF,
  parameter int PARITY_EN = 0
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       urx_p1,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  output logic       rx_ferr,
  output logic       rx_perr,
  output logic       rx_busy,
  output logic [2:0] state_dbg
);

  urx_state_e state;
  logic       urx_d;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       par_err;
  logic       fin;
  logic       stop_bit;
  logic       perr_q;

  logic start_edge;
  logic cnt_clr;
  logic tick_half;
  logic tick_full;

  assign start_edge = urx_d & ~urx_p1;
  assign cnt_clr    = (state == ST_IDLE) && start_edge;
  assign rx_busy    = (state != ST_IDLE);
  assign state_dbg  = state;
  // Parity errors can only exist in the 8E1 build.
  assign rx_perr    = (PARITY_EN != 0) ? perr_q : 1'b0;

  urx_baud_cnt #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_cnt (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .half_mode (state == ST_START),
    .tick_half (tick_half),
    .tick_full (tick_full)
  );

  // Frame FSM, shift register, parity tracking and registered result pulses.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      urx_d    <= 1'b1;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
      par_err  <= 1'b0;
      fin      <= 1'b0;
      stop_bit <= 1'b1;
      rx_data  <= 8'h00;
      rx_vld   <= 1'b0;
      rx_ferr  <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      urx_d   <= urx_p1;
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
      perr_q  <= 1'b0;
      fin     <= 1'b0;

      // Result of the frame whose stop bit was sampled last cycle;
      // a bad stop bit outranks a parity mismatch.
      if (fin) begin
        if (!stop_bit) begin
          rx_ferr <= 1'b1;
        end else if (par_err) begin
          perr_q <= 1'b1;
        end else begin
          rx_vld  <= 1'b1;
          rx_data <= shreg;
        end
      end

      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            state   <= ST_START;
            par_err <= 1'b0;
          end
        end
        ST_START: begin
          if (tick_half) begin
            if (!urx_p1) begin
              state   <= ST_DATA;
              bit_idx <= 3'd0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (tick_full) begin
            shreg   <= {urx_p1, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= (PARITY_EN != 0) ? ST_PAR : ST_STOP;
            end
          end
        end
        ST_PAR: begin
          if (tick_full) begin
            par_err <= urx_p1 ^ (^shreg);
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick_full) begin
            stop_bit <= urx_p1;
            fin      <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
